dmem_sram_resp: RTL

DMEM_SRAM_RESP -- requirements
Module: dmem_sram_resp

---
 rtl/cpu_defs.sv | 21 ++
 rtl/dmem_sram_resp_if.sv | 25 ++
 rtl/sram_be_gen.sv | 32 +++
 rtl/dmem_sram_resp.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: access-size encodings, response FSM states, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

   // data_size encodings on the CPU data port
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   // Wide enough for LATENCY-1 with LATENCY up to 15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

endpackage

// File: rtl/dmem_sram_resp_if.sv
// CPU data-port bundle: request (req/wr/size/addr/wdata) and response (addr_ok/data_ok/rdata/err).
// Latency: n/a (wires only).
// Backpressure: addr_ok qualifies req; data_ok is a one-cycle pulse with no stall.
// Modports: master = CPU side, slave = memory responder side.
interface dmem_sram_resp_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        data_err;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata, data_err
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata, data_err
   );
endinterface

// File: rtl/sram_be_gen.sv
// Byte-enable and alignment-error generation for one data-port access.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: size/addr/wr in; wen (per-byte write enable) and err (misaligned or illegal size) out.
module sram_be_gen
   import cpu_defs::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr,
   input  logic       wr,
   output logic [3:0] wen,
   output logic       err
);

   always_comb begin
      err = ((size == SZ_HALF) && addr[0])
         || ((size == SZ_WORD) && (addr != 2'd0))
         ||  (size == SZ_ILL);

      wen = 4'b0000;
      // A faulty access still goes to the RAM, but must never modify it
      if (wr && !err) begin
         case (size)
            SZ_BYTE: wen = 4'b0001 << addr;
            SZ_HALF: wen = 4'b0011 << {addr[1], 1'b0};
            SZ_WORD: wen = 4'b1111;
            default: wen = 4'b0000;
         endcase
      end
   end

endmodule

// File: rtl/dmem_sram_resp.sv
// CPU data port to synchronous SRAM bridge with a fixed, programmable response latency.
// Latency: data_ok exactly LATENCY cycles after the addr_ok cycle (LATENCY 1..15).
// Backpressure: one transaction outstanding; addr_ok only in IDLE or RESP, so a new
//   request may be accepted in the same cycle as the previous response.
// Ports: clk, resetn (sync, active-low), dmem (CPU data port, slave side),
//   ram_en/ram_wen/ram_addr/ram_wdata/ram_rdata (SRAM, 1-cycle read latency).
module dmem_sram_resp #(
   parameter int LATENCY = 2,
   parameter int IDX_W   = 16
) (
   input  logic               clk,
   input  logic               resetn,
   dmem_sram_resp_if.slave    dmem,
   output logic               ram_en,
   output logic [3:0]         ram_wen,
   output logic [IDX_W-1:0]   ram_addr,
   output logic [31:0]        ram_wdata,
   input  logic [31:0]        ram_rdata
);
   import cpu_defs::*;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   resp_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q;
   logic             err_q;
   logic             cap_q;     // a read was accepted last cycle: ram_rdata is valid now
   logic [31:0]      hold_q;
   logic             accept;
   logic             resp_vld;
   logic [3:0]       be_wen;
   logic             be_err;

   sram_be_gen u_be_gen (
      .size (dmem.data_size),
      .addr (dmem.data_addr[1:0]),
      .wr   (dmem.data_wr),
      .wen  (be_wen),
      .err  (be_err)
   );

   // Gating with resetn keeps every strobe low during a reset cycle, whatever the state
   assign accept = resetn && dmem.data_req && ((state_q == IDLE) || (state_q == RESP));

   assign dmem.data_addr_ok = accept;
   assign ram_en            = accept;
   assign ram_wen           = accept ? be_wen : 4'b0000;
   assign ram_addr          = dmem.data_addr[IDX_W+1:2];
   assign ram_wdata         = dmem.data_wdata;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      resp_vld = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            // <= rather than == so a corrupted zero count cannot wedge the FSM
            if (cnt_q <= 1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            resp_vld = 1'b1;
            if (accept) begin
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         cap_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= accept && !dmem.data_wr;
         if (cap_q) begin
            hold_q <= ram_rdata;
         end
         // Only an accept overwrites these, and that happens at the end of the
         // RESP cycle, after the current response has been presented
         if (accept) begin
            wr_q  <= dmem.data_wr;
            err_q <= be_err;
         end
      end
   end

   // With LATENCY=1 the response cycle is also the capture cycle, so bypass the
   // holding register and forward the RAM output directly.
   assign dmem.data_data_ok = resp_vld && resetn;
   assign dmem.data_err     = resp_vld && err_q;
   assign dmem.data_rdata   = (resp_vld && !wr_q) ? (cap_q ? ram_rdata : hold_q) : 32'h0;

   // Address bits above the RAM index are deliberately ignored
   if (IDX_W < 30) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^dmem.data_addr[31:IDX_W+2];
   end

endmodule
